// File: rtl/hscale_fir_sequencer_if.sv
// rtl/hscale_fir_sequencer_if.sv - line control, line-buffer read and FIR control bundle
interface hscale_fir_sequencer_if #(
    parameter int COEFF_W = 8,
    parameter int LEN_W   = 11
);
    logic               line_start_i;
    logic [LEN_W-1:0]   in_len_i;
    logic [LEN_W-1:0]   out_len_i;
    logic [COEFF_W:0]   hinc_i;
    logic               rden_o;
    logic [LEN_W-1:0]   rdaddr_o;
    logic [2:0]         fir_inopcode_o;
    logic [1:0]         fir_calcopcode_o;
    logic [COEFF_W-1:0] coeff_a0_o;
    logic [COEFF_W-1:0] coeff_a1_o;
    logic               out_valid_o;
    logic               out_last_o;
    logic               busy_o;
    logic               line_done_o;

    modport master (
        output line_start_i, in_len_i, out_len_i, hinc_i,
        input  rden_o, rdaddr_o, fir_inopcode_o, fir_calcopcode_o,
               coeff_a0_o, coeff_a1_o, out_valid_o, out_last_o, busy_o, line_done_o
    );

    modport slave (
        input  line_start_i, in_len_i, out_len_i, hinc_i,
        output rden_o, rdaddr_o, fir_inopcode_o, fir_calcopcode_o,
               coeff_a0_o, coeff_a1_o, out_valid_o, out_last_o, busy_o, line_done_o
    );
endinterface

// File: rtl/hscale_fir_sequencer.sv
// rtl/hscale_fir_sequencer.sv - two-tap polyphase FIR sequencer for horizontal upscaling
module hscale_fir_sequencer #(
    parameter int COEFF_W = 8,
    parameter int LEN_W   = 11,
    parameter int FIR_LAT = 3
) (
    input  logic                  CLK_i,
    input  logic                  nRST_i,
    hscale_fir_sequencer_if.slave bus
);
    localparam logic [COEFF_W:0] UNITY = {1'b1, {COEFF_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME0 = 3'd1,
        S_PRIME1 = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t             state_q, state_d;

    logic [LEN_W-1:0]   in_last_q;
    logic [LEN_W-1:0]   out_len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   addr_q;
    logic [COEFF_W:0]   hinc_q;
    logic [COEFF_W-1:0] phase_q;
    logic               rden_q;
    logic               done_q;
    logic [FIR_LAT-1:0] vpipe_q;
    logic [FIR_LAT-1:0] lpipe_q;

    logic [LEN_W-1:0]   in_last_s;
    logic [COEFF_W:0]   hinc_s;
    logic [COEFF_W:0]   phase_sum;
    logic               carry;
    logic               last_out;
    logic               run;
    logic               pend;
    logic [LEN_W-1:0]   next_addr;
    logic [LEN_W-1:0]   prime1_addr;

    logic               rden;
    logic [LEN_W-1:0]   rdaddr;
    logic [1:0]         calcop;
    logic [COEFF_W-1:0] a0;
    logic [COEFF_W-1:0] a1;

    // A zero-length input still has one pixel; out-of-range increments collapse to 1:1.
    assign in_last_s = (bus.in_len_i == '0) ? '0 : bus.in_len_i - LEN_W'(1);
    assign hinc_s    = (bus.hinc_i == '0 || bus.hinc_i > UNITY) ? UNITY : bus.hinc_i;

    assign phase_sum   = {1'b0, phase_q} + hinc_q;
    assign carry       = phase_sum[COEFF_W];
    assign last_out    = (cnt_q == out_len_q - LEN_W'(1));
    assign run         = (state_q == S_RUN);
    assign next_addr   = (addr_q == in_last_q) ? addr_q : addr_q + LEN_W'(1);
    assign prime1_addr = (in_last_q == '0) ? '0 : LEN_W'(1);

    // Results still in flight beyond the one emerging this cycle.
    always_comb begin
        pend = 1'b0;
        for (int i = 0; i < FIR_LAT - 1; i++) begin
            pend = pend | vpipe_q[i];
        end
    end

    // State register.
    always_ff @(posedge CLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an empty output line skips straight to the drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.line_start_i) begin
                    state_d = (bus.out_len_i == '0) ? S_DRAIN : S_PRIME0;
                end
            end
            S_PRIME0: state_d = S_PRIME1;
            S_PRIME1: state_d = S_RUN;
            S_RUN:    state_d = last_out ? S_DRAIN : S_RUN;
            S_DRAIN:  state_d = pend ? S_DRAIN : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Read strobe, address, calc opcode and coefficients for the current state.
    always_comb begin
        rden   = 1'b0;
        rdaddr = '0;
        calcop = 2'b00;
        a0     = '0;
        a1     = '0;
        case (state_q)
            S_PRIME0: begin
                rden = 1'b1;
            end
            S_PRIME1: begin
                rden   = 1'b1;
                rdaddr = prime1_addr;
            end
            S_RUN: begin
                rden   = carry && !last_out;
                rdaddr = rden ? next_addr : '0;
                if (phase_q == '0) begin
                    calcop = 2'b11;
                end else begin
                    a0 = phase_q;
                    a1 = COEFF_W'(UNITY - {1'b0, phase_q});
                end
            end
            default: ;
        endcase
    end

    // Line parameters, output counter, phase accumulator and last read address.
    always_ff @(posedge CLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            in_last_q <= '0;
            out_len_q <= '0;
            hinc_q    <= '0;
            cnt_q     <= '0;
            phase_q   <= '0;
            addr_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.line_start_i) begin
                        in_last_q <= in_last_s;
                        out_len_q <= bus.out_len_i;
                        hinc_q    <= hinc_s;
                        cnt_q     <= '0;
                        phase_q   <= '0;
                        addr_q    <= '0;
                    end
                end
                S_PRIME1: addr_q <= prime1_addr;
                S_RUN: begin
                    cnt_q   <= cnt_q + LEN_W'(1);
                    phase_q <= phase_sum[COEFF_W-1:0];
                    if (rden) begin
                        addr_q <= next_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Opcode alignment with buffer data, FIR latency tracking and end-of-line pulse.
    always_ff @(posedge CLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            rden_q  <= 1'b0;
            vpipe_q <= '0;
            lpipe_q <= '0;
            done_q  <= 1'b0;
        end else begin
            rden_q  <= rden;
            vpipe_q <= (vpipe_q << 1) | FIR_LAT'(run);
            lpipe_q <= (lpipe_q << 1) | FIR_LAT'(run && last_out);
            done_q  <= (state_q == S_DRAIN) && !pend;
        end
    end

    assign bus.rden_o           = rden;
    assign bus.rdaddr_o         = rdaddr;
    assign bus.fir_inopcode_o   = {2'b00, rden_q};
    assign bus.fir_calcopcode_o = calcop;
    assign bus.coeff_a0_o       = a0;
    assign bus.coeff_a1_o       = a1;
    assign bus.out_valid_o      = vpipe_q[FIR_LAT-1];
    assign bus.out_last_o       = lpipe_q[FIR_LAT-1];
    assign bus.busy_o           = (state_q != S_IDLE);
    assign bus.line_done_o      = done_q;
endmodule
